if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all state updates on its rising edge.
REQ-002 SHALL have ports: resetn  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 SHALL have ports: br_valid  in  1  one-cycle redirect request from the execute/decode side.
REQ-004 SHALL have ports: br_target  in  32  redirect PC, qualified by br_valid.
REQ-005 SHALL have ports: id_ready  in  1  downstream accepts the instruction this cycle.
REQ-006 SHALL have ports: inst_sram_en  out  1  SRAM read enable, asserted when a fetch request is issued.
REQ-007 SHALL have ports: inst_sram_we  out  1  constant 0.
REQ-008 SHALL have ports: inst_sram_addr  out  32  fetch address.
REQ-009 SHALL have ports: inst_sram_wdata  out  32  constant 0.
REQ-010 SHALL have ports: inst_sram_rdata  in  32  read data, valid exactly one cycle after en.
REQ-011 SHALL have ports: if_valid  out  1  if_pc/if_inst/if_adef valid.
REQ-012 SHALL have ports: if_pc  out  32  PC of the delivered instruction.
REQ-013 SHALL have ports: if_inst  out  32  delivered instruction word.
REQ-014 SHALL have ports: if_adef  out  1  misaligned-fetch flag (see Configuration).
REQ-015 SHALL have parameter: RESET_PC, default 32'h1c00_0000, meaning the first fetch address after reset.

Function
REQ-016 SHALL implement states IDLE, WAIT (request in flight, rdata arrives this cycle), HOLD (instruction latched, awaiting id_ready).
REQ-017 SHALL, in IDLE, issue en=1 with addr=fetch_pc and go to WAIT.
REQ-018 SHALL, in WAIT, drive if_valid=1 with if_inst=inst_sram_rdata (combinational pass-through) and if_pc=request PC.
REQ-019 SHALL, on WAIT with id_ready=1, issue the next request at if_pc+4 in the same cycle and stay in WAIT (throughput 1 instr/cycle).
REQ-020 SHALL, on WAIT with id_ready=0, latch rdata/pc into a hold register, issue no request, go to HOLD.
REQ-021 SHALL, in HOLD, drive if_valid=1 from the hold register; on id_ready=1 issue request at held pc+4 and go to WAIT.
REQ-022 SHALL compute sequential PC modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000).
REQ-023 SHALL, when br_valid=1 in any state, force if_valid=0 that cycle, discard the in-flight or held instruction, issue en=1 at br_target that same cycle, and go to WAIT.
REQ-024 SHALL give br_valid priority over a simultaneous id_ready; no handshake occurs in that cycle.
REQ-025 SHALL keep inst_sram_en=0 whenever no request is issued.

Reset
REQ-026 SHALL, while resetn=0, hold state IDLE, inst_sram_en=0, if_valid=0, if_pc=0, if_inst=0, if_adef=0, and fetch_pc=RESET_PC.
REQ-027 SHALL issue the first request (addr=RESET_PC) in the first cycle with resetn=1.
REQ-028 SHALL, if reset asserts mid-operation, drop any in-flight or held instruction without a handshake.

Configuration
REQ-029 SHALL, with IF_ADEF_EN defined, on any request PC with pc[1:0]!=0 suppress inst_sram_en, deliver if_valid=1, if_adef=1, if_inst=0 next cycle, and follow the normal handshake.
REQ-030 SHALL, without IF_ADEF_EN, tie if_adef=0 and fetch addr with pc[1:0] forced to 2'b00.

Structure
REQ-031 SHALL place the state encoding (IDLE/WAIT/HOLD) and the RESET_PC default in a shared package (cpu_defs).
REQ-032 SHALL be a single module; no sub-module is required.

Verification
REQ-033 SHALL cover reset release: resetn 0->1 -> en=1 addr=0x1c000000 in cycle 0; if_valid=1, if_pc=0x1c000000 in cycle 1.
REQ-034 SHALL cover streaming: id_ready held 1 -> addr 0x1c000000, 0x1c000004, 0x1c000008 on consecutive cycles, one handshake per cycle.
REQ-035 SHALL cover backpressure: id_ready=0 for 3 cycles with rdata changing -> if_inst stays at the latched word and en=0; on release the next addr is held pc+4.
REQ-036 SHALL cover redirect: br_valid=1, br_target=0x1c000100 while in HOLD -> if_valid=0, en=1 addr=0x1c000100; next cycle if_pc=0x1c000100.
REQ-037 SHALL cover simultaneous br_valid and id_ready -> no handshake counted, next if_pc=br_target.
REQ-038 SHALL cover the ADEF case: with IF_ADEF_EN defined, br_target=0x1c000102 -> en=0, next cycle if_valid=1, if_adef=1; without it, addr=0x1c000100.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU front-end definitions: datapath width, fetch FSM encoding and reset PC.
package cpu_defs;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h1c00_0000;
   localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
   localparam logic [XLEN-1:0] WORD_ADDR_MASK   = 32'hFFFF_FFFC;

   // IDLE: nothing in flight; WAIT: rdata arrives this cycle; HOLD: word latched, awaiting id_ready
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } if_state_e;

endpackage

// File: rtl/if_stage_if.sv
// Instruction SRAM port bundle between the fetch stage (master) and the memory (slave).
interface if_stage_if;
   import cpu_defs::*;

   logic            inst_sram_en;
   logic            inst_sram_we;
   logic [XLEN-1:0] inst_sram_addr;
   logic [XLEN-1:0] inst_sram_wdata;
   logic [XLEN-1:0] inst_sram_rdata;

   modport master (
      output inst_sram_en,
      output inst_sram_we,
      output inst_sram_addr,
      output inst_sram_wdata,
      input  inst_sram_rdata
   );

   modport slave (
      input  inst_sram_en,
      input  inst_sram_we,
      input  inst_sram_addr,
      input  inst_sram_wdata,
      output inst_sram_rdata
   );

endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: one-cycle-latency SRAM fetch with hold buffer and branch redirect.
// Optional misaligned-fetch exception reporting is enabled by defining IF_ADEF_EN.
module if_stage
   import cpu_defs::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            br_valid,
   input  logic [XLEN-1:0] br_target,
   input  logic            id_ready,
   if_stage_if.master      sram,
   output logic            if_valid,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_inst,
   output logic            if_adef
);

   if_state_e       state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] inst_q, inst_d;
   logic            adef_q, adef_d;

   logic            req_c;
   logic [XLEN-1:0] req_pc_c;
   logic [XLEN-1:0] req_addr_c;
   logic            req_bad_c;
   logic            deliver_c;

`ifdef IF_ADEF_EN
   assign req_bad_c  = (req_pc_c[1:0] != 2'b00);
   assign req_addr_c = req_pc_c;
`else
   assign req_bad_c  = 1'b0;
   assign req_addr_c = req_pc_c & WORD_ADDR_MASK;
`endif

   // Next-state and request selection; a redirect overrides any handshake or hold decision
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      adef_d    = adef_q;
      req_c     = 1'b0;
      req_pc_c  = pc_q + PC_STEP;
      deliver_c = 1'b0;

      unique case (state_q)
         IDLE: begin
            req_c    = 1'b1;
            req_pc_c = RESET_PC;
         end
         WAIT: begin
            deliver_c = 1'b1;
            if (id_ready) begin
               req_c = 1'b1;
            end else begin
               state_d = HOLD;
               inst_d  = adef_q ? '0 : sram.inst_sram_rdata;
            end
         end
         HOLD: begin
            deliver_c = 1'b1;
            if (id_ready) req_c = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (br_valid) begin
         deliver_c = 1'b0;
         req_c     = 1'b1;
         req_pc_c  = br_target;
         inst_d    = inst_q;
      end

      if (req_c) begin
         state_d = WAIT;
         pc_d    = req_addr_c;
         adef_d  = req_bad_c;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         pc_q    <= '0;
         inst_q  <= '0;
         adef_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         adef_q  <= adef_d;
      end
   end

   assign sram.inst_sram_en    = resetn & req_c & ~req_bad_c;
   assign sram.inst_sram_we    = 1'b0;
   assign sram.inst_sram_addr  = req_addr_c;
   assign sram.inst_sram_wdata = '0;

   // Delivery side: WAIT passes rdata straight through, HOLD replays the latched word
   always_comb begin
      if_valid = resetn & deliver_c;
      if_pc    = '0;
      if_inst  = '0;
      if_adef  = 1'b0;
      if (resetn && (state_q != IDLE)) begin
         if_pc   = pc_q;
         if_adef = adef_q;
         if (!adef_q) if_inst = (state_q == WAIT) ? sram.inst_sram_rdata : inst_q;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized traffic against a
// transaction-level model of the fetch stream (one pending delivery slot, SRAM as a hash of the address).
module tb_if_stage;
   import cpu_defs::*;

`ifdef IF_ADEF_EN
   localparam bit ADEF = 1'b1;
`else
   localparam bit ADEF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        resetn;
   logic        br_valid;
   logic [31:0] br_target;
   logic        id_ready;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_adef;

   if_stage_if sram_if ();

   if_stage dut (
      .clk       (clk),
      .resetn    (resetn),
      .br_valid  (br_valid),
      .br_target (br_target),
      .id_ready  (id_ready),
      .sram      (sram_if),
      .if_valid  (if_valid),
      .if_pc     (if_pc),
      .if_inst   (if_inst),
      .if_adef   (if_adef)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fails  = 0;

   // Model: is an instruction owed to decode, which PC, and was its fetch misaligned
   bit          m_pend = 1'b0;
   logic [31:0] m_pc   = '0;
   bit          m_adef = 1'b0;
   logic        exp_en, exp_valid, exp_adef;
   logic [31:0] exp_addr, exp_pc, exp_inst;
   bit          last_en = 1'b0;
   logic [31:0] last_addr = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   function automatic logic [31:0] fetch_addr(input logic [31:0] pc);
      return ADEF ? pc : (pc & 32'hFFFF_FFFC);
   endfunction

   // Drive one cycle's inputs, let logic settle, compute expectations and advance the model
   task automatic apply(input bit rst, input bit br, input logic [31:0] tgt, input bit rdy);
      logic [31:0] req_pc;
      bit          req;
      bit          bad;
      resetn    = rst;
      br_valid  = br;
      br_target = tgt;
      id_ready  = rdy;
      sram_if.inst_sram_rdata = last_en ? mem_word(last_addr) : 32'($urandom);
      #2;
      exp_en = 1'b0; exp_addr = '0; exp_valid = 1'b0;
      exp_pc = '0; exp_inst = '0; exp_adef = 1'b0;
      if (!rst) begin
         m_pend = 1'b0;
      end else begin
         exp_valid = m_pend && !br;
         exp_pc    = m_pc;
         exp_adef  = m_adef;
         exp_inst  = m_adef ? 32'h0 : mem_word(m_pc);
         req = 1'b1;
         req_pc = '0;
         if (br)          req_pc = tgt;
         else if (!m_pend) req_pc = RESET_PC_DEFAULT;
         else if (rdy)    req_pc = m_pc + 32'd4;
         else             req = 1'b0;
         if (req) begin
            bad      = ADEF && (req_pc[1:0] != 2'b00);
            exp_en   = !bad;
            exp_addr = fetch_addr(req_pc);
            m_pend   = 1'b1;
            m_pc     = fetch_addr(req_pc);
            m_adef   = bad;
         end
      end
      last_en   = sram_if.inst_sram_en;
      last_addr = sram_if.inst_sram_addr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      for (int i = 0; i < 2; i++) begin
         apply(1'b0, 1'b0, '0, 1'b0);
         tick();
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         apply(1'b0, 1'($urandom), 32'($urandom), 1'($urandom));
         n_checks++; if (sram_if.inst_sram_en !== 1'b0) begin n_fails++; $display("FAIL reset_en: got %0b want 0", sram_if.inst_sram_en); end
         n_checks++; if (if_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid: got %0b want 0", if_valid); end
         n_checks++; if (if_pc !== 32'h0) begin n_fails++; $display("FAIL reset_pc: got %h want 0", if_pc); end
         n_checks++; if (if_inst !== 32'h0) begin n_fails++; $display("FAIL reset_inst: got %h want 0", if_inst); end
         n_checks++; if (if_adef !== 1'b0) begin n_fails++; $display("FAIL reset_adef: got %0b want 0", if_adef); end
         tick();
      end
   endtask

   task automatic test_reset_release();
      apply(1'b1, 1'b0, '0, 1'b0);
      n_checks++; if (sram_if.inst_sram_en !== 1'b1) begin n_fails++; $display("FAIL rel_en: got %0b want 1", sram_if.inst_sram_en); end
      n_checks++; if (sram_if.inst_sram_addr !== 32'h1c00_0000) begin n_fails++; $display("FAIL rel_addr: got %h want 1c000000", sram_if.inst_sram_addr); end
      n_checks++; if (if_valid !== 1'b0) begin n_fails++; $display("FAIL rel_valid0: got %0b want 0", if_valid); end
      tick();
      apply(1'b1, 1'b0, '0, 1'b1);
      n_checks++; if (if_valid !== 1'b1) begin n_fails++; $display("FAIL rel_valid1: got %0b want 1", if_valid); end
      n_checks++; if (if_pc !== 32'h1c00_0000) begin n_fails++; $display("FAIL rel_pc: got %h want 1c000000", if_pc); end
      n_checks++; if (if_inst !== mem_word(32'h1c00_0000)) begin n_fails++; $display("FAIL rel_inst: got %h want %h", if_inst, mem_word(32'h1c00_0000)); end
      tick();
   endtask

   task automatic test_streaming();
      logic [31:0] a;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         apply(1'b1, 1'b0, '0, 1'b1);
         a = 32'h1c00_0000 + 32'(4 * i);
         n_checks++; if (sram_if.inst_sram_en !== 1'b1 || sram_if.inst_sram_addr !== a) begin n_fails++; $display("FAIL stream_req[%0d]: got en=%0b addr=%h want en=1 addr=%h", i, sram_if.inst_sram_en, sram_if.inst_sram_addr, a); end
         n_checks++; if (if_valid !== (i > 0)) begin n_fails++; $display("FAIL stream_valid[%0d]: got %0b want %0b", i, if_valid, (i > 0)); end
         if (i > 0) begin
            n_checks++; if (if_pc !== a - 32'd4 || if_inst !== mem_word(a - 32'd4)) begin n_fails++; $display("FAIL stream_data[%0d]: got pc=%h inst=%h want pc=%h inst=%h", i, if_pc, if_inst, a - 32'd4, mem_word(a - 32'd4)); end
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      for (int j = 0; j < 4; j++) begin
         apply(1'b1, 1'b0, '0, (j == 3));
         n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h1c00_000c || if_inst !== mem_word(32'h1c00_000c)) begin n_fails++; $display("FAIL bp_hold[%0d]: got v=%0b pc=%h inst=%h want v=1 pc=1c00000c inst=%h", j, if_valid, if_pc, if_inst, mem_word(32'h1c00_000c)); end
         n_checks++; if (sram_if.inst_sram_en !== (j == 3)) begin n_fails++; $display("FAIL bp_en[%0d]: got %0b want %0b", j, sram_if.inst_sram_en, (j == 3)); end
         tick();
      end
      n_checks++; if (last_addr !== 32'h1c00_0010) begin n_fails++; $display("FAIL bp_next_addr: got %h want 1c000010", last_addr); end
      apply(1'b1, 1'b0, '0, 1'b0);
      n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h1c00_0010) begin n_fails++; $display("FAIL bp_after: got v=%0b pc=%h want v=1 pc=1c000010", if_valid, if_pc); end
      tick();
   endtask

   task automatic test_redirect_hold();
      apply(1'b1, 1'b1, 32'h1c00_0100, 1'b0);
      n_checks++; if (if_valid !== 1'b0) begin n_fails++; $display("FAIL redir_valid: got %0b want 0", if_valid); end
      n_checks++; if (sram_if.inst_sram_en !== 1'b1 || sram_if.inst_sram_addr !== 32'h1c00_0100) begin n_fails++; $display("FAIL redir_req: got en=%0b addr=%h want en=1 addr=1c000100", sram_if.inst_sram_en, sram_if.inst_sram_addr); end
      tick();
      apply(1'b1, 1'b0, '0, 1'b0);
      n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h1c00_0100 || if_inst !== mem_word(32'h1c00_0100)) begin n_fails++; $display("FAIL redir_next: got v=%0b pc=%h inst=%h want v=1 pc=1c000100 inst=%h", if_valid, if_pc, if_inst, mem_word(32'h1c00_0100)); end
      tick();
   endtask

   task automatic test_br_and_ready();
      apply(1'b1, 1'b1, 32'h1c00_0200, 1'b1);
      n_checks++; if (if_valid !== 1'b0) begin n_fails++; $display("FAIL brrdy_valid: got %0b want 0", if_valid); end
      n_checks++; if (sram_if.inst_sram_en !== 1'b1 || sram_if.inst_sram_addr !== 32'h1c00_0200) begin n_fails++; $display("FAIL brrdy_req: got en=%0b addr=%h want en=1 addr=1c000200", sram_if.inst_sram_en, sram_if.inst_sram_addr); end
      tick();
      apply(1'b1, 1'b0, '0, 1'b0);
      n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h1c00_0200) begin n_fails++; $display("FAIL brrdy_next: got v=%0b pc=%h want v=1 pc=1c000200", if_valid, if_pc); end
      tick();
   endtask

   task automatic test_adef();
      logic [31:0] want_pc;
      want_pc = ADEF ? 32'h1c00_0102 : 32'h1c00_0100;
      apply(1'b1, 1'b1, 32'h1c00_0102, 1'b0);
      n_checks++; if (sram_if.inst_sram_en !== !ADEF) begin n_fails++; $display("FAIL adef_en: got %0b want %0b", sram_if.inst_sram_en, !ADEF); end
      n_checks++; if (sram_if.inst_sram_addr !== want_pc) begin n_fails++; $display("FAIL adef_addr: got %h want %h", sram_if.inst_sram_addr, want_pc); end
      tick();
      apply(1'b1, 1'b0, '0, 1'b0);
      n_checks++; if (if_valid !== 1'b1 || if_adef !== ADEF || if_pc !== want_pc) begin n_fails++; $display("FAIL adef_next: got v=%0b adef=%0b pc=%h want v=1 adef=%0b pc=%h", if_valid, if_adef, if_pc, ADEF, want_pc); end
      n_checks++; if (if_inst !== (ADEF ? 32'h0 : mem_word(32'h1c00_0100))) begin n_fails++; $display("FAIL adef_inst: got %h", if_inst); end
      tick();
   endtask

   task automatic test_wrap();
      apply(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
      tick();
      apply(1'b1, 1'b0, '0, 1'b1);
      n_checks++; if (if_pc !== 32'hFFFF_FFFC || sram_if.inst_sram_addr !== 32'h0 || sram_if.inst_sram_en !== 1'b1) begin n_fails++; $display("FAIL wrap_req: got pc=%h addr=%h en=%0b want pc=fffffffc addr=0 en=1", if_pc, sram_if.inst_sram_addr, sram_if.inst_sram_en); end
      tick();
      apply(1'b1, 1'b0, '0, 1'b1);
      n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== mem_word(32'h0)) begin n_fails++; $display("FAIL wrap_data: got v=%0b pc=%h inst=%h want v=1 pc=0 inst=%h", if_valid, if_pc, if_inst, mem_word(32'h0)); end
      tick();
   endtask

   task automatic test_mid_reset();
      apply(1'b0, 1'b0, '0, 1'b1);
      n_checks++; if (if_valid !== 1'b0 || sram_if.inst_sram_en !== 1'b0) begin n_fails++; $display("FAIL midrst: got v=%0b en=%0b want 0 0", if_valid, sram_if.inst_sram_en); end
      tick();
      apply(1'b1, 1'b0, '0, 1'b1);
      n_checks++; if (if_valid !== 1'b0 || sram_if.inst_sram_addr !== 32'h1c00_0000 || sram_if.inst_sram_en !== 1'b1) begin n_fails++; $display("FAIL midrst_restart: got v=%0b en=%0b addr=%h want v=0 en=1 addr=1c000000", if_valid, sram_if.inst_sram_en, sram_if.inst_sram_addr); end
      tick();
   endtask

   task automatic test_random();
      bit          rst, br, rdy;
      logic [31:0] tgt;
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 39) != 0);
         br  = ($urandom_range(0, 5) == 0);
         rdy = 1'($urandom);
         tgt = 32'($urandom);
         if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
         if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF0;
         apply(rst, br, tgt, rdy);
         n_checks++; if (sram_if.inst_sram_en !== exp_en) begin n_fails++; $display("FAIL rnd_en[%0d]: got %0b want %0b", i, sram_if.inst_sram_en, exp_en); end
         if (exp_en) begin
            n_checks++; if (sram_if.inst_sram_addr !== exp_addr) begin n_fails++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, sram_if.inst_sram_addr, exp_addr); end
         end
         n_checks++; if (if_valid !== exp_valid) begin n_fails++; $display("FAIL rnd_valid[%0d]: got %0b want %0b", i, if_valid, exp_valid); end
         if (exp_valid || !rst) begin
            n_checks++; if (if_pc !== exp_pc || if_inst !== exp_inst || if_adef !== exp_adef) begin n_fails++; $display("FAIL rnd_data[%0d]: got pc=%h inst=%h adef=%0b want pc=%h inst=%h adef=%0b", i, if_pc, if_inst, if_adef, exp_pc, exp_inst, exp_adef); end
         end
         n_checks++; if (sram_if.inst_sram_we !== 1'b0 || sram_if.inst_sram_wdata !== 32'h0) begin n_fails++; $display("FAIL rnd_wr[%0d]: got we=%0b wdata=%h want 0 0", i, sram_if.inst_sram_we, sram_if.inst_sram_wdata); end
         tick();
      end
   endtask

   initial begin
      resetn    = 1'b0;
      br_valid  = 1'b0;
      br_target = '0;
      id_ready  = 1'b0;
      sram_if.inst_sram_rdata = '0;
      #1;
      test_reset();
      test_reset_release();
      test_streaming();
      test_backpressure();
      test_redirect_hold();
      test_br_and_ready();
      test_adef();
      test_wrap();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
